gpr_seq_ctrl: RTL and testbench
===============================

Name: gpr_seq_ctrl

Overview:
Command sequencer sitting directly upstream of the 4-bit general-purpose shift register (gpr). Accepts one register operation per valid/ready handshake and drives the gpr's sel, d, l_in and r_in for the required number of cycles. Reads the gpr output back to form the arithmetic-shift and rotate serial inputs. Pulses done when the result is stable in the register.

Parameters:
WIDTH, 4, register width; must match the gpr.
CNT_W, 3, width of the shift-count field; maximum count is 2^CNT_W-1.

Ports:
clk  input  1  system clock; all state updates on the rising edge
clr  input  1  asynchronous, active-low reset; shares the net with the gpr clear
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command (IDLE only)
cmd_op  input  3  operation code, see Behaviour
cmd_data  input  WIDTH  parallel-load value (LOAD only)
cmd_cnt  input  CNT_W  number of shift cycles (shift/rotate ops)
q_in  input  WIDTH  gpr output q, fed back
sel  output  2  to gpr: 00 hold, 01 shift right (l_in enters MSB), 10 shift left (r_in enters LSB), 11 load
d  output  WIDTH  to gpr parallel data
l_in  output  1  to gpr MSB serial input
r_in  output  1  to gpr LSB serial input
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse

Behaviour:
- Op codes:
  - 000 NOP
  - 001 LOAD (d=cmd_data)
  - 010 CLR (load zero)
  - 011 SHR logical (l_in=0)
  - 100 ASR (l_in=q_in[WIDTH-1])
  - 101 ROR (l_in=q_in[0])
  - 110 SHL logical (r_in=0)
  - 111 ROL (r_in=q_in[WIDTH-1])
- l_in and r_in are combinational from q_in and the registered op, valid only in RUN; otherwise 0.
- Reset (clr=0, asynchronous): state=IDLE, sel=00, d=0, busy=0, done=0, counter=0, latched op=NOP. cmd_ready=1 once clr releases.
- IDLE: cmd_ready=1, sel=00. Accept on the edge where cmd_valid&cmd_ready. Latch op, data and count.
  - LOAD/CLR: counter=1.
  - Shift ops: counter=cmd_cnt.
  - NOP, or a shift op with cmd_cnt=0: counter=0, go to DONE.
  - Otherwise go to RUN.
- RUN: sel=op encoding (LOAD/CLR 11, SHR/ASR/ROR 01, SHL/ROL 10); d=latched data (0 for CLR, 0 for shifts). Counter decrements each edge; the edge with counter==1 moves to DONE.
- DONE: sel=00, done=1, cmd_ready=0, busy=1; next edge goes to IDLE.
- Latency: accept at edge T. The RUN cycle count is N (the counter value); done is high in cycle T+1+N and the gpr holds the final result in that cycle.
- Throughput: next accept no earlier than the edge ending the DONE cycle +1, i.e. no back-to-back acceptance while busy. cmd_valid held during busy is ignored, not dropped; it is accepted in the following IDLE cycle.
- Count wraps never: max count 2^CNT_W-1 executes exactly that many shifts.
- Reset mid-RUN: immediate return to reset values; no done pulse is emitted for the aborted command.

Decomposition:
- Package gpr_pkg:
  - sel encodings SEL_HOLD/SEL_SHR/SEL_SHL/SEL_LOAD
  - 3-bit op code constants
  - state enum IDLE/RUN/DONE
  - sel encodings shared with the gpr testbench
- No sub-module: the FSM, down-counter and serial-in mux live in one module.

Test Plan:
1. LOAD cmd_data=1011 accepted at T -> sel=11, d=1011 for one cycle; done=1 at T+2; q=1011.
2. LOAD 1001, then ASR cnt=2 -> sel=01 for two cycles with l_in=1; q 1001->1100->1110; done at T+3.
3. LOAD 1011, then ROL cnt=4 -> sel=10 four cycles, r_in tracks q[3]; q 0111,1110,1101,1011; done at T+5.
4. SHL cnt=0 -> sel stays 00, done at T+1, q unchanged; NOP behaves identically.
5. cmd_valid held high with two queued commands -> second accepted only in the IDLE cycle after done; cmd_ready=0 throughout RUN/DONE.
6. SHR cnt=5 from 1111, clr asserted after 2 RUN cycles -> sel=00, busy=0, done=0 asynchronously; no done pulse after release; cmd_ready=1 next cycle.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared encodings for the 4-bit general-purpose shift register and its sequencer.
package gpr_pkg;

    // gpr select encodings
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;  // l_in enters MSB
    localparam logic [1:0] SEL_SHL  = 2'b10;  // r_in enters LSB
    localparam logic [1:0] SEL_LOAD = 2'b11;

    // command op codes
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_CLR  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_ROL  = 3'b111;

    // sequencer states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // gpr select value driven while an op is running
    function automatic logic [1:0] op_sel(input logic [2:0] op);
        logic [1:0] s;
        s = SEL_HOLD;
        case (op)
            OP_LOAD, OP_CLR:        s = SEL_LOAD;
            OP_SHR, OP_ASR, OP_ROR: s = SEL_SHR;
            OP_SHL, OP_ROL:         s = SEL_SHL;
            default:                s = SEL_HOLD;
        endcase
        return s;
    endfunction

    // true for the five shift/rotate ops, which take their cycle count from the command
    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_ASR) || (op == OP_ROR) ||
               (op == OP_SHL) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/gpr_seq_ctrl.sv
// Command sequencer driving the gpr: one op per handshake, counted RUN phase, done pulse.
module gpr_seq_ctrl
    import gpr_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] q_in,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] d,
    output logic             l_in,
    output logic             r_in,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run;
    logic             accept;

    // Only the end bits of q feed the serial inputs.
    logic unused_q_mid;
    assign unused_q_mid = ^q_in[WIDTH-2:1];

    assign run       = (state_q == ST_RUN);
    assign cmd_ready = (state_q == ST_IDLE) && clr;
    assign accept    = cmd_valid && cmd_ready;

    // Next-state: latch the command in IDLE, count down in RUN, DONE lasts one cycle
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = cmd_op;
                    data_d = (cmd_op == OP_LOAD) ? cmd_data : '0;
                    if ((cmd_op == OP_LOAD) || (cmd_op == OP_CLR)) begin
                        cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (is_shift(cmd_op)) begin
                        cnt_d = cmd_cnt;
                    end else begin
                        cnt_d = '0;
                    end
                    state_d = (cnt_d == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched command registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // gpr controls and serial inputs; all idle outside RUN
    always_comb begin
        sel  = run ? op_sel(op_q) : SEL_HOLD;
        d    = run ? data_q : '0;
        l_in = 1'b0;
        r_in = 1'b0;
        if (run) begin
            case (op_q)
                OP_ASR:  l_in = q_in[WIDTH-1];
                OP_ROR:  l_in = q_in[0];
                OP_ROL:  r_in = q_in[WIDTH-1];
                default: begin
                    l_in = 1'b0;
                    r_in = 1'b0;
                end
            endcase
        end
        busy = run || (state_q == ST_DONE);
        done = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_gpr_seq_ctrl.sv
// Self-checking bench for gpr_seq_ctrl with a behavioural 4-bit gpr closing the loop.
module tb_gpr_seq_ctrl;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd_op = 3'd0;
    logic [W-1:0]  cmd_data = '0;
    logic [CW-1:0] cmd_cnt = '0;
    logic          cmd_ready;
    logic [1:0]    sel;
    logic [W-1:0]  d;
    logic          l_in;
    logic          r_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  q;

    int            n_pass = 0;
    int            n_total = 0;
    logic [W-1:0]  exp_q = '0;

    always #5 clk = ~clk;

    gpr_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .q_in      (q),
        .sel       (sel),
        .d         (d),
        .l_in      (l_in),
        .r_in      (r_in),
        .busy      (busy),
        .done      (done)
    );

    // Environment: the shift register the sequencer controls
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) q <= '0;
        else begin
            case (sel)
                2'b01:   q <= {l_in, q[W-1:1]};
                2'b10:   q <= {q[W-2:0], r_in};
                2'b11:   q <= d;
                default: q <= q;
            endcase
        end
    end

    // Reference: RUN cycles per command
    function automatic int ref_cycles(input logic [2:0] op, input int cnt);
        case (op)
            3'd0:    return 0;
            3'd1,
            3'd2:    return 1;
            default: return cnt;
        endcase
    endfunction

    // Reference: sel driven during RUN
    function automatic logic [1:0] ref_sel(input logic [2:0] op);
        case (op)
            3'd1, 3'd2:       return 2'b11;
            3'd3, 3'd4, 3'd5: return 2'b01;
            3'd6, 3'd7:       return 2'b10;
            default:          return 2'b00;
        endcase
    endfunction

    // Reference: register value once the whole command has completed
    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] qv,
                                                input logic [W-1:0] data, input int cnt);
        int v;
        int s;
        int k;
        v = int'(qv);
        k = cnt % W;
        s = (v >= (1 << (W - 1))) ? v - (1 << W) : v;
        case (op)
            3'd0:    return qv;
            3'd1:    return data;
            3'd2:    return '0;
            3'd3:    return W'(v >> cnt);
            3'd4:    return W'(s >>> cnt);
            3'd5:    return W'((v >> k) | (v << (W - k)));
            3'd6:    return W'(v << cnt);
            default: return W'((v << k) | (v >> (W - k)));
        endcase
    endfunction

    // Issue one command from an IDLE negedge and check every cycle through the next IDLE.
    // While busy the inputs switch to the "next" command (held valid if hold=1).
    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] data,
                           input logic [CW-1:0] cnt, input logic hold, input logic [2:0] nop,
                           input logic [W-1:0] ndata, input logic [CW-1:0] ncnt,
                           input string tag);
        int n;
        logic [1:0]   es;
        logic [W-1:0] ed;
        logic [W+4:0] ev;
        logic [W+4:0] ov;
        n  = ref_cycles(op, int'(cnt));
        es = ref_sel(op);
        ed = (op == 3'd1) ? data : '0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL %s accept: cmd_ready got %b want 1", tag, cmd_ready);
        else n_pass++;
        @(posedge clk);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_valid = hold;
                cmd_op    = nop;
                cmd_data  = ndata;
                cmd_cnt   = ncnt;
            end
            ev = (k <= n) ? {1'b1, 1'b0, 1'b0, es, ed} : {3'b110, 2'b00, {W{1'b0}}};
            ov = {busy, done, cmd_ready, sel, d};
            n_total++;
            if (ov !== ev)
                $display("FAIL %s cyc%0d {busy,done,ready,sel,d} got %b want %b", tag, k, ov, ev);
            else n_pass++;
        end
        exp_q = ref_result(op, exp_q, data, int'(cnt));
        n_total++;
        if (q !== exp_q) $display("FAIL %s result q got %b want %b", tag, q, exp_q);
        else n_pass++;
        @(negedge clk);
        ov = {busy, done, cmd_ready, sel, d};
        ev = {3'b001, 2'b00, {W{1'b0}}};
        n_total++;
        if (ov !== ev) $display("FAIL %s idle {busy,done,ready,sel,d} got %b want %b", tag, ov, ev);
        else n_pass++;
    endtask

    task automatic idle_cycle(input string tag);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, done, cmd_ready, sel} !== 5'b00100)
            $display("FAIL %s gap {busy,done,ready,sel} got %b want 00100", tag,
                     {busy, done, cmd_ready, sel});
        else n_pass++;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        #12;
        n_total++;
        if ({busy, done, sel, d, l_in, r_in} !== '0)
            $display("FAIL reset outputs got %b want 0", {busy, done, sel, d, l_in, r_in});
        else n_pass++;
        @(negedge clk);
        clr = 1'b1;
        exp_q = '0;
        @(negedge clk);
        n_total++;
        if ({cmd_ready, busy, done} !== 3'b100)
            $display("FAIL reset release {ready,busy,done} got %b want 100", {cmd_ready, busy, done});
        else n_pass++;
    endtask

    task automatic test_load();
        run_cmd(3'd1, 4'b1011, 3'd0, 1'b0, 3'd0, '0, '0, "load");
        run_cmd(3'd2, 4'b0101, 3'd6, 1'b0, 3'd0, '0, '0, "clr");
    endtask

    task automatic test_asr();
        run_cmd(3'd1, 4'b1001, 3'd0, 1'b0, 3'd0, '0, '0, "asr_load");
        run_cmd(3'd4, 4'b0000, 3'd2, 1'b0, 3'd0, '0, '0, "asr2");
    endtask

    task automatic test_rol();
        run_cmd(3'd1, 4'b1011, 3'd0, 1'b0, 3'd0, '0, '0, "rol_load");
        run_cmd(3'd7, 4'b0000, 3'd4, 1'b0, 3'd0, '0, '0, "rol4");
        run_cmd(3'd5, 4'b0000, 3'd7, 1'b0, 3'd0, '0, '0, "ror7_max");
    endtask

    task automatic test_zero_count();
        run_cmd(3'd6, 4'b1111, 3'd0, 1'b0, 3'd0, '0, '0, "shl0");
        run_cmd(3'd0, 4'b1111, 3'd5, 1'b0, 3'd0, '0, '0, "nop");
    endtask

    task automatic test_back_to_back();
        run_cmd(3'd1, 4'b0110, 3'd0, 1'b1, 3'd3, 4'b0000, 3'd3, "b2b_first");
        run_cmd(3'd3, 4'b0000, 3'd3, 1'b1, 3'd6, 4'b0000, 3'd1, "b2b_second");
        run_cmd(3'd6, 4'b0000, 3'd1, 1'b0, 3'd0, '0, '0, "b2b_third");
    endtask

    task automatic test_reset_mid_run();
        run_cmd(3'd1, 4'b1111, 3'd0, 1'b0, 3'd0, '0, '0, "abort_load");
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_data  = '0;
        cmd_cnt   = 3'd5;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        exp_q = '0;
        n_total++;
        if ({busy, done, sel, d, l_in} !== '0)
            $display("FAIL abort outputs got %b want 0", {busy, done, sel, d, l_in});
        else n_pass++;
        @(negedge clk);
        clr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_total++;
            if ({busy, done, cmd_ready} !== 3'b001)
                $display("FAIL abort after release cyc%0d {busy,done,ready} got %b want 001", k,
                         {busy, done, cmd_ready});
            else n_pass++;
        end
        n_total++;
        if (q !== exp_q) $display("FAIL abort q got %b want %b", q, exp_q);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0]    op;
        logic [W-1:0]  data;
        logic [CW-1:0] cnt;
        int            gap;
        for (int i = 0; i < 40; i++) begin
            op   = 3'($urandom_range(0, 7));
            data = W'($urandom);
            cnt  = CW'($urandom_range(0, 7));
            gap  = int'($urandom_range(0, 2));
            run_cmd(op, data, cnt, 1'b0, 3'd0, '0, '0, "random");
            for (int g = 0; g < gap; g++) idle_cycle("random");
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_asr();
        test_rol();
        test_zero_count();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        run_cmd(3'd1, 4'b1100, 3'd0, 1'b0, 3'd0, '0, '0, "post_abort");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
